// File: rtl/vending_controller_if.sv
// Coin/select/restock inputs and dispense/change/status outputs of the vending controller.
// The controller uses the slave modport; the coin-mechanism side uses the master modport.
interface vending_controller_if;
  localparam int unsigned CREDIT_W = 7;
  localparam int unsigned STOCK_W  = 3;

  logic [1:0]          money;
  logic [1:0]          select;
  logic                restock;
  logic [1:0]          item;
  logic                change;
  logic                reject;
  logic                deny;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock20;
  logic [STOCK_W-1:0]  stock50;

  modport master (
    output money, select, restock,
    input  item, change, reject, deny, busy, credit, stock20, stock50
  );

  modport slave (
    input  money, select, restock,
    output item, change, reject, deny, busy, credit, stock20, stock50
  );
endinterface

// File: rtl/vending_controller.sv
// Two-item vending controller: accepts 10/50 coins, vends 20/50 items, returns change in tens.
// Every output is a register; pulse outputs last exactly one cycle.
module vending_controller #(
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned MAX_STOCK  = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  vending_controller_if.slave bus
);

  localparam int unsigned CREDIT_W = 7;
  localparam int unsigned STOCK_W  = 3;
  localparam int unsigned SUM_W    = 8;

  localparam logic [CREDIT_W-1:0] PRICE20    = CREDIT_W'(20);
  localparam logic [CREDIT_W-1:0] PRICE50    = CREDIT_W'(50);
  localparam logic [CREDIT_W-1:0] COIN10     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] COIN50     = CREDIT_W'(50);
  localparam logic [SUM_W-1:0]    CREDIT_CAP = SUM_W'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(MAX_STOCK);

  localparam logic [1:0] MONEY_TEN   = 2'b01;
  localparam logic [1:0] MONEY_FIFTY = 2'b10;
  localparam logic [1:0] SEL_NONE    = 2'b00;
  localparam logic [1:0] SEL_I20     = 2'b01;
  localparam logic [1:0] SEL_I50     = 2'b10;
  localparam logic [1:0] ITEM_20     = 2'b01;
  localparam logic [1:0] ITEM_50     = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic [CREDIT_W-1:0] credit_q,  credit_d;
  logic [STOCK_W-1:0]  stock20_q, stock20_d;
  logic [STOCK_W-1:0]  stock50_q, stock50_d;
  logic                sel50_q,   sel50_d;
  logic [1:0]          item_q,    item_d;
  logic                change_q,  change_d;
  logic                reject_q,  reject_d;
  logic                deny_q,    deny_d;
  logic                busy_q,    busy_d;

  logic                coin_valid_c;
  logic [CREDIT_W-1:0] coin_val_c;
  logic [SUM_W-1:0]    coin_sum_c;
  logic                coin_fits_c;
  logic [CREDIT_W-1:0] price_c;

  // Coin decode; the sum is one bit wider so the ceiling test cannot wrap
  always_comb begin
    coin_valid_c = (bus.money == MONEY_TEN) || (bus.money == MONEY_FIFTY);
    coin_val_c   = (bus.money == MONEY_FIFTY) ? COIN50 : COIN10;
    coin_sum_c   = SUM_W'(credit_q) + SUM_W'(coin_val_c);
    coin_fits_c  = (coin_sum_c <= CREDIT_CAP);
    price_c      = sel50_q ? PRICE50 : PRICE20;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    stock20_d = stock20_q;
    stock50_d = stock50_q;
    sel50_d   = sel50_q;
    item_d    = 2'b00;
    change_d  = 1'b0;
    reject_d  = 1'b0;
    deny_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.restock) begin
          stock20_d = STOCK_FULL;
          stock50_d = STOCK_FULL;
        end
        if (coin_valid_c) begin
          if (coin_fits_c) begin
            credit_d = CREDIT_W'(coin_sum_c);
            state_d  = CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      CREDIT: begin
        if (bus.select != SEL_NONE) begin
          // A select wins the cycle; a coin arriving with it is handed back
          reject_d = coin_valid_c;
          if (bus.select == SEL_I20) begin
            if ((credit_q >= PRICE20) && (stock20_q != '0)) begin
              sel50_d = 1'b0;
              state_d = VEND;
            end else begin
              deny_d = 1'b1;
            end
          end else if (bus.select == SEL_I50) begin
            if ((credit_q >= PRICE50) && (stock50_q != '0)) begin
              sel50_d = 1'b1;
              state_d = VEND;
            end else begin
              deny_d = 1'b1;
            end
          end else begin
            state_d = (credit_q == '0) ? IDLE : CHANGE;
          end
        end else if (coin_valid_c) begin
          if (coin_fits_c) begin
            credit_d = CREDIT_W'(coin_sum_c);
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      VEND: begin
        reject_d = coin_valid_c;
        item_d   = sel50_q ? ITEM_50 : ITEM_20;
        credit_d = (credit_q >= price_c) ? (credit_q - price_c) : '0;
        if (sel50_q) begin
          if (stock50_q != '0) stock50_d = stock50_q - STOCK_W'(1);
        end else begin
          if (stock20_q != '0) stock20_d = stock20_q - STOCK_W'(1);
        end
        state_d = (credit_d != '0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        reject_d = coin_valid_c;
        if (credit_q != '0) begin
          change_d = 1'b1;
          credit_d = (credit_q >= COIN10) ? (credit_q - COIN10) : '0;
        end
        state_d = (credit_d == '0) ? IDLE : CHANGE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      stock20_q <= STOCK_FULL;
      stock50_q <= STOCK_FULL;
      sel50_q   <= 1'b0;
      item_q    <= 2'b00;
      change_q  <= 1'b0;
      reject_q  <= 1'b0;
      deny_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      stock20_q <= stock20_d;
      stock50_q <= stock50_d;
      sel50_q   <= sel50_d;
      item_q    <= item_d;
      change_q  <= change_d;
      reject_q  <= reject_d;
      deny_q    <= deny_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.item    = item_q;
  assign bus.change  = change_q;
  assign bus.reject  = reject_q;
  assign bus.deny    = deny_q;
  assign bus.busy    = busy_q;
  assign bus.credit  = credit_q;
  assign bus.stock20 = stock20_q;
  assign bus.stock50 = stock50_q;

endmodule

// File: tb/tb_vending_controller.sv
// Scenario bench for vending_controller: expected pulses are queued with the edge they
// must appear on and matched against the DUT outputs sampled 1 time unit after each edge.
module tb_vending_controller;

  localparam logic [1:0] M_NONE  = 2'b00;
  localparam logic [1:0] M_TEN   = 2'b01;
  localparam logic [1:0] M_FIFTY = 2'b10;
  localparam logic [1:0] S_NONE  = 2'b00;
  localparam logic [1:0] S_I20   = 2'b01;
  localparam logic [1:0] S_I50   = 2'b10;
  localparam logic [1:0] S_CANCL = 2'b11;
  localparam logic [1:0] K_ITEM  = 2'd0;
  localparam logic [1:0] K_CHG   = 2'd1;
  localparam logic [1:0] K_REJ   = 2'd2;
  localparam logic [1:0] K_DENY  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  val;
    logic [15:0] cyc;
  } ev_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cyc   = '0;
  int          n_checks = 0;
  int          n_fail   = 0;
  ev_t         exp_q[$];

  vending_controller_if bus ();

  vending_controller #(.MAX_CREDIT(100), .MAX_STOCK(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic expect_ev(input logic [1:0] kind, input logic [1:0] val, input logic [15:0] at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then score every pulse seen after the edge
  task automatic tick(input logic [1:0] m, input logic [1:0] s, input logic r);
    ev_t e;
    ev_t o;
    bus.money   = m;
    bus.select  = s;
    bus.restock = r;
    @(posedge clk);
    cyc = cyc + 16'd1;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] v;
      case (k)
        0:       v = bus.item;
        1:       v = {1'b0, bus.change};
        2:       v = {1'b0, bus.reject};
        default: v = {1'b0, bus.deny};
      endcase
      if (v != 2'b00) begin
        o.kind = 2'(k);
        o.val  = v;
        o.cyc  = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse kind=%0d val=%0d cyc=%0d, required no pulse", k, v, cyc);
        end else begin
          e = exp_q.pop_front();
          if (o !== e)
            begin
              n_fail++;
              $display("FAIL pulse_match got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                       o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
            end
        end
      end
    end
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse kind=%0d val=%0d at cyc=%0d, observed none by cyc=%0d",
               e.kind, e.val, e.cyc, cyc);
    end
  endtask

  task automatic test_reset();
    bus.money = M_NONE; bus.select = S_NONE; bus.restock = 1'b0;
    rst_n = 1'b0;
    tick(M_FIFTY, S_NONE, 1'b0);
    tick(M_NONE, S_NONE, 1'b0);
    n_checks += 4;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL reset_credit got=%0d want=0", bus.credit); end
    if (bus.stock20 !== 3'd7 || bus.stock50 !== 3'd7) begin
      n_fail++; $display("FAIL reset_stock got=%0d/%0d want=7/7", bus.stock20, bus.stock50);
    end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if ({bus.item, bus.change, bus.reject, bus.deny} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses got=%b want=00000", {bus.item, bus.change, bus.reject, bus.deny});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vend_exact();
    tick(M_TEN, S_NONE, 1'b0);
    tick(M_TEN, S_NONE, 1'b0);
    n_checks++;
    if (bus.credit !== 7'd20) begin n_fail++; $display("FAIL exact_credit20 got=%0d want=20", bus.credit); end
    tick(M_NONE, S_I20, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL exact_busy_vend got=%b want=1", bus.busy); end
    expect_ev(K_ITEM, 2'b01, cyc + 16'd1);
    tick(M_NONE, S_NONE, 1'b0);
    n_checks += 3;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL exact_credit0 got=%0d want=0", bus.credit); end
    if (bus.stock20 !== 3'd6) begin n_fail++; $display("FAIL exact_stock20 got=%0d want=6", bus.stock20); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL exact_idle_busy got=%b want=0", bus.busy); end
    tick(M_NONE, S_I20, 1'b0);
    tick(M_NONE, S_NONE, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL exact_queue left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_vend_change();
    logic [15:0] n;
    tick(M_FIFTY, S_NONE, 1'b0);
    tick(M_TEN, S_NONE, 1'b0);
    n_checks++;
    if (bus.credit !== 7'd60) begin n_fail++; $display("FAIL change_credit60 got=%0d want=60", bus.credit); end
    tick(M_NONE, S_I20, 1'b0);
    n = cyc;
    expect_ev(K_ITEM, 2'b01, n + 16'd1);
    for (int i = 2; i <= 5; i++) expect_ev(K_CHG, 2'b01, n + 16'(i));
    tick(M_NONE, S_NONE, 1'b0);
    n_checks += 2;
    if (bus.credit !== 7'd40) begin n_fail++; $display("FAIL change_after_vend got=%0d want=40", bus.credit); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL change_busy got=%b want=1", bus.busy); end
    for (int i = 0; i < 4; i++) tick(M_NONE, S_NONE, 1'b0);
    n_checks += 3;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL change_credit0 got=%0d want=0", bus.credit); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL change_idle got=%b want=0", bus.busy); end
    if (bus.stock20 !== 3'd5) begin n_fail++; $display("FAIL change_stock20 got=%0d want=5", bus.stock20); end
    tick(M_NONE, S_NONE, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL change_queue left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_overflow_refund();
    logic [15:0] n;
    tick(M_FIFTY, S_NONE, 1'b0);
    tick(M_FIFTY, S_NONE, 1'b0);
    expect_ev(K_REJ, 2'b01, cyc + 16'd1);
    tick(M_FIFTY, S_NONE, 1'b0);
    n_checks++;
    if (bus.credit !== 7'd100) begin n_fail++; $display("FAIL ovf_credit got=%0d want=100", bus.credit); end
    tick(M_NONE, S_CANCL, 1'b0);
    n = cyc;
    for (int i = 1; i <= 10; i++) expect_ev(K_CHG, 2'b01, n + 16'(i));
    for (int i = 0; i < 5; i++) tick(M_NONE, S_NONE, 1'b0);
    n_checks++;
    if (bus.credit !== 7'd50) begin n_fail++; $display("FAIL ovf_mid_credit got=%0d want=50", bus.credit); end
    for (int i = 0; i < 5; i++) tick(M_NONE, S_NONE, 1'b0);
    n_checks += 2;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL ovf_refund_credit got=%0d want=0", bus.credit); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ovf_refund_busy got=%b want=0", bus.busy); end
    tick(M_NONE, S_NONE, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_queue left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_stock_out();
    logic [15:0] n;
    for (int i = 0; i < 7; i++) begin
      tick(M_FIFTY, S_NONE, 1'b0);
      tick(M_NONE, S_I50, 1'b0);
      expect_ev(K_ITEM, 2'b10, cyc + 16'd1);
      tick(M_NONE, S_NONE, 1'b0);
    end
    n_checks++;
    if (bus.stock50 !== 3'd0) begin n_fail++; $display("FAIL stock_empty got=%0d want=0", bus.stock50); end
    tick(M_FIFTY, S_NONE, 1'b0);
    tick(M_NONE, S_NONE, 1'b1);
    n_checks++;
    if (bus.stock50 !== 3'd0) begin n_fail++; $display("FAIL stock_restock_in_credit got=%0d want=0", bus.stock50); end
    expect_ev(K_DENY, 2'b01, cyc + 16'd1);
    tick(M_NONE, S_I50, 1'b0);
    n_checks += 2;
    if (bus.credit !== 7'd50) begin n_fail++; $display("FAIL stock_deny_credit got=%0d want=50", bus.credit); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stock_deny_busy got=%b want=0", bus.busy); end
    tick(M_NONE, S_CANCL, 1'b0);
    n = cyc;
    for (int i = 1; i <= 5; i++) expect_ev(K_CHG, 2'b01, n + 16'(i));
    for (int i = 0; i < 5; i++) tick(M_NONE, S_NONE, 1'b0);
    tick(M_NONE, S_NONE, 1'b1);
    n_checks += 3;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL stock_refund_credit got=%0d want=0", bus.credit); end
    if (bus.stock50 !== 3'd7 || bus.stock20 !== 3'd7) begin
      n_fail++; $display("FAIL stock_restock_idle got=%0d/%0d want=7/7", bus.stock20, bus.stock50);
    end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stock_queue left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_same_cycle();
    tick(M_TEN, S_NONE, 1'b0);
    expect_ev(K_REJ, 2'b01, cyc + 16'd1);
    expect_ev(K_DENY, 2'b01, cyc + 16'd1);
    tick(M_TEN, S_I20, 1'b0);
    n_checks += 2;
    if (bus.credit !== 7'd10) begin n_fail++; $display("FAIL same_credit got=%0d want=10", bus.credit); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL same_busy got=%b want=0", bus.busy); end
    tick(M_NONE, S_CANCL, 1'b0);
    expect_ev(K_CHG, 2'b01, cyc + 16'd1);
    tick(M_NONE, S_NONE, 1'b0);
    tick(M_NONE, S_NONE, 1'b0);
    n_checks += 2;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL same_refund got=%0d want=0", bus.credit); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL same_queue left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_change();
    tick(M_FIFTY, S_NONE, 1'b0);
    tick(M_NONE, S_I20, 1'b0);
    expect_ev(K_ITEM, 2'b01, cyc + 16'd1);
    tick(M_NONE, S_NONE, 1'b0);
    n_checks += 2;
    if (bus.credit !== 7'd30) begin n_fail++; $display("FAIL rst_pre_credit got=%0d want=30", bus.credit); end
    if (bus.stock20 !== 3'd6) begin n_fail++; $display("FAIL rst_pre_stock20 got=%0d want=6", bus.stock20); end
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL rst_async_credit got=%0d want=0", bus.credit); end
    if (bus.stock20 !== 3'd7) begin n_fail++; $display("FAIL rst_async_stock20 got=%0d want=7", bus.stock20); end
    if ({bus.item, bus.change, bus.busy} !== 4'b0) begin
      n_fail++; $display("FAIL rst_async_outputs got=%b want=0000", {bus.item, bus.change, bus.busy});
    end
    tick(M_NONE, S_NONE, 1'b0);
    tick(M_NONE, S_NONE, 1'b0);
    rst_n = 1'b1;
    tick(M_NONE, S_NONE, 1'b0);
    tick(M_TEN, S_NONE, 1'b0);
    n_checks++;
    if (bus.credit !== 7'd10) begin n_fail++; $display("FAIL rst_first_edge got=%0d want=10", bus.credit); end
    tick(M_NONE, S_CANCL, 1'b0);
    expect_ev(K_CHG, 2'b01, cyc + 16'd1);
    tick(M_NONE, S_NONE, 1'b0);
    tick(M_NONE, S_NONE, 1'b0);
    n_checks += 2;
    if (bus.credit !== 7'd0) begin n_fail++; $display("FAIL rst_refund got=%0d want=0", bus.credit); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_queue left=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_vend_exact();
    test_vend_change();
    test_overflow_refund();
    test_stock_out();
    test_same_cycle();
    test_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
